// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - sync, debounce and decode of fire button and row/col switches
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire_btn,
  input  logic [3:0] sw_raw,
  input  logic       nrow_raw,
  output logic [3:0] row_sel,
  output logic [3:0] col_sel,
  output logic       error,
  output logic       fire_pulse,
  output logic       fire_reject
);

  // Bit layout of the conditioned input word: [3:0] switches, [4] fire, [5] row/col mode.
  localparam int NB       = 6;
  localparam int FIRE_BIT = 4;
  localparam int NROW_BIT = 5;

  // The counter value on which the next mismatching cycle commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0] raw_w;
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] stable_w;

  assign raw_w = {nrow_raw, fire_btn, sw_raw};

  // Two-stage synchroniser, plain flop-to-flop with nothing in between.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NB; g++) begin : g_db
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             stable_q;
      logic             stable_d;

      // Count consecutive disagreeing cycles; agreement restarts the count, and the
      // count clears again on the cycle the new level is accepted, so it never wraps.
      always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q[g] != stable_q) begin
          if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q[g];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // Debounce state for this bit; reset discards any partial count.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
        end
      end

      assign stable_w[g] = stable_q;
    end
  endgenerate

  logic [3:0] sw_stable;
  logic       fire_stable;
  logic       nrow_stable;
  logic [2:0] sw_cnt;
  logic       sw_valid;
  logic       sw_multi;
  logic       fire_rise;
  logic [3:0] row_sel_d;
  logic [3:0] col_sel_d;

  assign sw_stable   = stable_w[3:0];
  assign fire_stable = stable_w[FIRE_BIT];
  assign nrow_stable = stable_w[NROW_BIT];

  logic [3:0] row_sel_q;
  logic [3:0] col_sel_q;
  logic       error_q;
  logic       fire_pulse_q;
  logic       fire_reject_q;
  logic       fire_stable_d_q;

  // Decode of the debounced switch word and fire edge; a switch word settling on the
  // same cycle as the fire press is already the one the fire decision sees.
  always_comb begin
    sw_cnt    = {2'b00, sw_stable[0]} + {2'b00, sw_stable[1]}
              + {2'b00, sw_stable[2]} + {2'b00, sw_stable[3]};
    sw_valid  = (sw_cnt == 3'd1);
    sw_multi  = (sw_cnt > 3'd1);
    row_sel_d = (sw_valid && !nrow_stable) ? sw_stable : 4'b0000;
    col_sel_d = (sw_valid &&  nrow_stable) ? sw_stable : 4'b0000;
    fire_rise = fire_stable & ~fire_stable_d_q;
  end

  // Output register: selects and the fire strobe update on the same edge so the cell
  // array always sees an enable consistent with the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_sel_q       <= 4'b0000;
      col_sel_q       <= 4'b0000;
      error_q         <= 1'b0;
      fire_pulse_q    <= 1'b0;
      fire_reject_q   <= 1'b0;
      fire_stable_d_q <= 1'b0;
    end else begin
      row_sel_q       <= row_sel_d;
      col_sel_q       <= col_sel_d;
      error_q         <= sw_multi;
      fire_pulse_q    <= fire_rise & sw_valid;
      fire_reject_q   <= fire_rise & ~sw_valid;
      fire_stable_d_q <= fire_stable;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_sel     = col_sel_q;
  assign error       = error_q;
  assign fire_pulse  = fire_pulse_q;
  assign fire_reject = fire_reject_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner
module tb_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fire_btn = 1'b0;
  logic [3:0] sw_raw = 4'b0000;
  logic       nrow_raw = 1'b0;
  logic [3:0] row_sel;
  logic [3:0] col_sel;
  logic       error;
  logic       fire_pulse;
  logic       fire_reject;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  int reject_cnt = 0;
  int p0, r0;

  input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .fire_btn   (fire_btn),
    .sw_raw     (sw_raw),
    .nrow_raw   (nrow_raw),
    .row_sel    (row_sel),
    .col_sel    (col_sel),
    .error      (error),
    .fire_pulse (fire_pulse),
    .fire_reject(fire_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: inputs pass a 2-cycle delay line, a level is accepted once the last
  // D delayed samples all disagree with the current level, outputs follow the decode rules.
  logic [5:0] m_s1 = '0, m_s2 = '0, m_st = '0, m_new;
  logic       m_fd = 1'b0;
  logic [5:0] hist[$];
  logic [3:0] exp_row = '0, exp_col = '0;
  logic       exp_err = 1'b0, exp_pulse = 1'b0, exp_rej = 1'b0;
  int         m_cnt;
  logic       m_valid, m_rise, all_diff;

  always @(posedge clk) begin
    if (reset) begin
      exp_row = '0; exp_col = '0; exp_err = 1'b0; exp_pulse = 1'b0; exp_rej = 1'b0;
      m_s1 = '0; m_s2 = '0; m_st = '0; m_fd = 1'b0;
      hist.delete();
    end else begin
      m_cnt     = $countones(m_st[3:0]);
      m_valid   = (m_cnt == 1);
      exp_err   = (m_cnt > 1);
      exp_row   = (m_valid && !m_st[5]) ? m_st[3:0] : 4'b0000;
      exp_col   = (m_valid &&  m_st[5]) ? m_st[3:0] : 4'b0000;
      m_rise    = m_st[4] && !m_fd;
      exp_pulse = m_rise && m_valid;
      exp_rej   = m_rise && !m_valid;
      m_fd      = m_st[4];
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      m_new = m_st;
      if (hist.size() == D) begin
        for (int b = 0; b < 6; b++) begin
          all_diff = 1'b1;
          foreach (hist[i]) if (hist[i][b] == m_st[b]) all_diff = 1'b0;
          if (all_diff) m_new[b] = ~m_st[b];
        end
      end
      m_st = m_new;
      m_s2 = m_s1;
      m_s1 = {nrow_raw, fire_btn, sw_raw};
    end
    #1;
    tests++;
    if ({row_sel, col_sel, error, fire_pulse, fire_reject} !==
        {exp_row, exp_col, exp_err, exp_pulse, exp_rej}) begin
      fails++;
      $display("FAIL model_cmp: got row=%b col=%b err=%b pulse=%b rej=%b expected row=%b col=%b err=%b pulse=%b rej=%b at %0t",
               row_sel, col_sel, error, fire_pulse, fire_reject,
               exp_row, exp_col, exp_err, exp_pulse, exp_rej, $time);
    end
  end

  // Strobe counters used by the directed checks.
  always @(posedge clk) begin
    #1;
    if (fire_pulse === 1'b1) pulse_cnt++;
    if (fire_reject === 1'b1) reject_cnt++;
  end

  initial begin
    // 1: reset, then hold reset with fire pressed
    edges(3);
    chk("reset_outputs", {row_sel, col_sel}, 8'h00);
    chk("reset_flags", {5'b0, error, fire_pulse, fire_reject}, 8'h00);
    chk("model_reset", {exp_row, exp_col}, 8'h00);
    fire_btn = 1'b1;
    p0 = pulse_cnt; r0 = reject_cnt;
    edges(10);
    chk("no_strobe_in_reset", 8'(pulse_cnt - p0 + reject_cnt - r0), 8'd0);
    fire_btn = 1'b0;
    reset = 1'b0;
    edges(10);

    // 2: row select latency
    nrow_raw = 1'b0; sw_raw = 4'b0100;
    edges(6);
    chk("row_before_latency", {4'b0, row_sel}, 8'h00);
    edges(1);
    chk("row_at_latency", {row_sel, col_sel}, 8'h40);
    chk("model_row_at_latency", {exp_row, exp_col}, 8'h40);
    chk("row_no_error", {7'b0, error}, 8'd0);

    // 3: column select and a held fire press
    sw_raw = 4'b0010; nrow_raw = 1'b1;
    edges(10);
    chk("col_select", {row_sel, col_sel}, 8'h02);
    fire_btn = 1'b1;
    p0 = pulse_cnt;
    edges(6);
    chk("fire_before_latency", 8'(pulse_cnt - p0), 8'd0);
    edges(1);
    chk("fire_at_latency", {6'b0, fire_pulse, fire_reject}, 8'h02);
    chk("model_fire_at_latency", {6'b0, exp_pulse, exp_rej}, 8'h02);
    edges(13);
    fire_btn = 1'b0;
    edges(10);
    chk("fire_hold_one_pulse", 8'(pulse_cnt - p0), 8'd1);

    // 4: short glitches, split by one quiet cycle, never accepted
    p0 = pulse_cnt; r0 = reject_cnt;
    fire_btn = 1'b1; edges(3);
    fire_btn = 1'b0; edges(1);
    fire_btn = 1'b1; edges(3);
    fire_btn = 1'b0; edges(12);
    chk("glitch_no_strobe", 8'(pulse_cnt - p0 + reject_cnt - r0), 8'd0);

    // 5: multi-bit word rejects, empty word rejects
    sw_raw = 4'b0110;
    edges(10);
    chk("multi_error", {7'b0, error}, 8'd1);
    chk("multi_no_select", {row_sel, col_sel}, 8'h00);
    p0 = pulse_cnt; r0 = reject_cnt;
    fire_btn = 1'b1; edges(10);
    fire_btn = 1'b0; edges(10);
    chk("multi_reject", 8'(reject_cnt - r0), 8'd1);
    chk("multi_no_pulse", 8'(pulse_cnt - p0), 8'd0);
    sw_raw = 4'b0000;
    edges(10);
    chk("empty_no_error", {error, 3'b0, row_sel}, 8'h00);
    r0 = reject_cnt;
    fire_btn = 1'b1; edges(10);
    fire_btn = 1'b0; edges(10);
    chk("empty_reject", 8'(reject_cnt - r0), 8'd1);

    // 6: reset mid-count while fire held
    sw_raw = 4'b1000; nrow_raw = 1'b0;
    edges(10);
    fire_btn = 1'b1;
    edges(4);
    reset = 1'b1;
    edges(2);
    chk("midcount_reset_outputs", {row_sel, col_sel}, 8'h00);
    chk("midcount_reset_flags", {5'b0, error, fire_pulse, fire_reject}, 8'h00);
    reset = 1'b0;
    p0 = pulse_cnt;
    edges(6);
    chk("post_reset_before_latency", 8'(pulse_cnt - p0), 8'd0);
    edges(1);
    chk("post_reset_pulse", {6'b0, fire_pulse, fire_reject}, 8'h02);
    chk("post_reset_row", {row_sel, col_sel}, 8'h80);
    edges(5);
    fire_btn = 1'b0;
    edges(10);

    // Random phase against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) sw_raw[b] = ~sw_raw[b];
      if ($urandom_range(5) == 0) fire_btn = ~fire_btn;
      if ($urandom_range(9) == 0) nrow_raw = ~nrow_raw;
      reset = ($urandom_range(299) == 0);
    end
    reset = 1'b0;
    edges(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
